// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: default widths, the queue entry layout and
// the NOP word decode inserts as a bubble.
package fetch_pkg;

    localparam int FETCH_ADDRESS_BITS = 16;
    localparam int FETCH_DATA_WIDTH   = 32;
    localparam int FETCH_QUEUE_DEPTH  = 4;

    // addi x0, x0, 0
    localparam logic [FETCH_DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_ADDRESS_BITS-1:0] pc;
        logic [FETCH_DATA_WIDTH-1:0]   instr;
        logic                          misaligned;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [FETCH_ADDRESS_BITS-1:0] pc);
        return |pc[1:0];
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode. The master side
// is the surrounding pipeline; the slave side is the queue itself.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int ADDRESS_BITS = FETCH_ADDRESS_BITS,
    parameter int DATA_WIDTH   = FETCH_DATA_WIDTH,
    parameter int DEPTH        = FETCH_QUEUE_DEPTH
);
    localparam int LEVEL_BITS = $clog2(DEPTH) + 1;

    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [ADDRESS_BITS-1:0] in_pc;
    logic [DATA_WIDTH-1:0]   in_instr;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDRESS_BITS-1:0] out_pc;
    logic [DATA_WIDTH-1:0]   out_instr;
    logic                    out_misaligned;
    logic [LEVEL_BITS-1:0]   level;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_misaligned, level
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_misaligned, level
    );

endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of (pc, instr, misaligned) between fetch and decode, with
// valid/ready on both sides and a single-cycle flush on redirect.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDRESS_BITS = FETCH_ADDRESS_BITS,
    parameter int DATA_WIDTH   = FETCH_DATA_WIDTH,
    parameter int DEPTH        = FETCH_QUEUE_DEPTH
) (
    input logic          clock,
    input logic          reset,
    fetch_queue_if.slave bus
);
    localparam int PTR_BITS   = $clog2(DEPTH);
    localparam int LEVEL_BITS = PTR_BITS + 1;

    localparam logic [PTR_BITS-1:0]   PTR_ONE   = PTR_BITS'(1);
    localparam logic [LEVEL_BITS-1:0] LEVEL_ONE = LEVEL_BITS'(1);
    localparam logic [LEVEL_BITS-1:0] LEVEL_MAX = LEVEL_BITS'(DEPTH);

    typedef struct packed {
        logic [ADDRESS_BITS-1:0] pc;
        logic [DATA_WIDTH-1:0]   instr;
        logic                    misaligned;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [LEVEL_BITS-1:0] count;
    logic [LEVEL_BITS-1:0] count_next;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    entry_t                in_entry;

    // Handshake flags come from registered state only, so out_ready never
    // reaches in_ready combinationally: a full queue refuses even while popping.
    assign full  = (count == LEVEL_MAX);
    assign empty = (count == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = ~empty & bus.out_ready;

    assign in_entry.pc         = bus.in_pc;
    assign in_entry.instr      = bus.in_instr;
    assign in_entry.misaligned = |bus.in_pc[1:0];

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + LEVEL_ONE;
            2'b01:   count_next = count - LEVEL_ONE;
            default: count_next = count;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register in
    // this block samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // NOTE: the array is reset too, because the head entry is visible on
            // out_* even when empty and must read as zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
        end
    end

    assign bus.in_ready       = ~full;
    assign bus.out_valid      = ~empty;
    assign bus.level          = count;
    assign bus.out_pc         = mem[rd_ptr].pc;
    assign bus.out_instr      = mem[rd_ptr].instr;
    assign bus.out_misaligned = mem[rd_ptr].misaligned;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling queue between the fetch stage and decode. Captures (PC, instruction) pairs produced by fetch/instruction memory into a DEPTH-entry FIFO and presents them in order to decode over a valid/ready handshake. Applies backpressure to fetch via `in_ready` and discards all buffered entries on a control-flow redirect (`flush`, driven by the same condition as fetch's `next_PC_select`).

## Interface
- ADDRESS_BITS, 16: PC width, matches fetch.
- DATA_WIDTH, 32: instruction word width.
- DEPTH, 4: entry count; power of two, ≥ 2.

- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; one clock; all state cleared while low.
- flush  input  1  synchronous redirect; empties queue.
- in_valid  input  1  fetch offers an entry.
- in_ready  output  1  queue can accept; equals !full.
- in_pc  input  ADDRESS_BITS  PC of offered instruction.
- in_instr  input  DATA_WIDTH  instruction word.
- out_valid  output  1  head entry valid; equals level != 0.
- out_ready  input  1  decode consumes head.
- out_pc  output  ADDRESS_BITS  head PC.
- out_instr  output  DATA_WIDTH  head instruction.
- out_misaligned  output  1  head PC had in_pc[1:0] != 0 at push.
- level  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH-entry array of {pc, instr, misaligned}; read pointer, write pointer (clog2(DEPTH) bits, natural wrap DEPTH-1 → 0), occupancy counter.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Push: write entry at write pointer; misaligned = |in_pc[1:0]; write pointer +1.
- Pop: read pointer +1.
- level next = level + push − pop; push and pop in one cycle leave level unchanged, both pointers advance.
- Full (level == DEPTH): in_ready = 0; in_valid ignored, even if a pop occurs that cycle (no same-cycle slot reuse).
- Empty (level == 0): out_valid = 0; out_ready ignored; out_pc/out_instr/out_misaligned show the stale entry at the read pointer (don't-care for consumers).
- Flush (priority over push and pop): next cycle level = 0, both pointers = 0; entry offered with flush is dropped; head popped with flush counts as discarded. Array contents need not be cleared.
- reset low: pointers, level, and all array entries → 0; held while low; normal operation from the first rising edge after release.

## Timing
- Reset values: in_ready = 1, out_valid = 0, level = 0, out_pc = 0, out_instr = 0, out_misaligned = 0.
- Latency: entry pushed at edge N is visible on out_* with out_valid = 1 after edge N (usable in cycle N+1); no combinational bypass from in_* to out_*.
- in_ready, out_valid, level depend only on registered state; no combinational path from out_ready to in_ready or from in_valid to out_valid.
- out_* are a combinational read of the array at the read pointer; stable while out_valid & !out_ready.
- Flush asserted in cycle N: out_valid = 0 and in_ready = 1 from cycle N+1.
- Throughput: one push and one pop per cycle sustained when 0 < level < DEPTH.

## Structure
- Shared package `fetch_pkg`: ADDRESS_BITS/DATA_WIDTH defaults, `fetch_entry_t` struct {pc, instr, misaligned}, NOP encoding 32'h0000_0013 for decode-side bubble use.
- No sub-module; pointer/counter logic and storage array live in `fetch_queue`.

## Test plan
- Reset: hold reset low 2 cycles with in_valid = 1 → in_ready = 1, out_valid = 0, level = 0, out_pc = 0, out_instr = 0 throughout; no entry accepted.
- Fill/drain: out_ready = 0, push PC 0x0000, 0x0004, 0x0008, 0x000C (instr 0xA0..0xA3) → level 4, in_ready = 0, 5th push (0x0010) rejected; then out_ready = 1 → out_pc 0x0000, 0x0004, 0x0008, 0x000C on consecutive cycles, then out_valid = 0.
- Wrap/stream: push and pop every cycle for 10 entries, PC 0x0000 step 4 → level constant at 1, outputs in order, pointers wrap cleanly past DEPTH.
- Flush: level 3, assert flush with in_valid = 1 (PC 0x0002) and out_ready = 1 → next cycle level = 0, out_valid = 0; PC 0x0002 never appears at output.
- Misaligned/redirect: after flush push PC 0x0002 then 0x0004 → out_misaligned = 1 then 0; out_pc 0x0002 then 0x0004.
- Mid-operation reset: level 2, pull reset low asynchronously between edges → level = 0, out_valid = 0, in_ready = 1 immediately, before the next clock edge.
